pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter unit for the multicycle MIPS core. It holds the architectural PC in a clocked register and computes the next PC: sequential, conditional branch, absolute jump, or register jump. A small return-address stack (RAS) serves `jal`/`jr $ra` pairs. The PC updates only in the controller's PC-update state, and the block reports misaligned targets and RAS overflow/underflow.

## Interface
- `XLEN`, 32: PC/datapath width, at least 28.
- `RESET_VEC`, 32'h0000_0000: PC value after reset.
- `RAS_DEPTH`, 4: RAS entries, at least 2.
- `STATE_W`, 6: width of the controller state code.
- `UPDATE_STATE`, 6'b000001: state code in which the PC may update.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `state`  in  STATE_W  controller state.
- `pc_en`  in  1  PC write enable.
- `stall`  in  1  freeze; overrides `pc_en`.
- `sel`  in  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 register jump.
- `br_taken`  in  1  branch condition, used only when `sel`=01.
- `br_offset`  in  XLEN  sign-extended word offset.
- `jtarget`  in  26  J-format target field.
- `jr_target`  in  XLEN  register operand for `sel`=11.
- `link`  in  1  push the return address (`pc_plus4`) onto the RAS.
- `ret`  in  1  with `sel`=11, take the target from the RAS top.
- `pc_out`  out  XLEN  registered PC.
- `pc_plus4`  out  XLEN  `pc_out`+4, combinational.
- `ras_top`  out  XLEN  current top entry; 0 when empty.
- `ras_count`  out  $clog2(RAS_DEPTH+1)  number of valid entries.
- `ras_overflow`  out  1  sticky: a push was made while full.
- `ras_underflow`  out  1  sticky: a pop was attempted while empty.
- `misalign`  out  1  one-cycle pulse: an update was rejected.

## Operation
- Update condition: `upd` = (`state`==UPDATE_STATE) & `pc_en` & ~`stall` & ~`reset`. When `upd` is 0, the PC, RAS and sticky flags hold.
- Next PC, with all arithmetic modulo 2^XLEN:
  - `sel`=00: `pc_out`+4.
  - `sel`=01: if `br_taken`, `pc_out`+4+(`br_offset`<<2); otherwise `pc_out`+4.
  - `sel`=10: {`pc_plus4`[XLEN-1:28], `jtarget`, 2'b00}.
  - `sel`=11: if `ret` and `ras_count`>0, `ras_top`; otherwise `jr_target`.
- Misalign: if `upd` and the selected target has [1:0]≠0 (possible only for `sel`=11), then:
  - `pc_out` holds;
  - the RAS is untouched, and no push or pop occurs;
  - `misalign` pulses high for the following cycle.
- RAS pop: occurs on `upd` & `sel`=11 & `ret`.
  - If `ras_count`>0, remove the top entry.
  - If `ras_count`=0, use `jr_target`, set `ras_underflow`, and leave the count at 0.
- RAS push: occurs on `upd` & `link`. It pushes the pre-update `pc_plus4`.
  - If full, discard the oldest entry (circular), keep `ras_count` at RAS_DEPTH, and set `ras_overflow`.
- Simultaneous push and pop (`link` & `ret` & `sel`=11):
  - Pop first: the target is the old top.
  - Then the pushed value replaces it; net `ras_count` is unchanged.
  - With an empty stack, underflow is set and the count becomes 1.
- `link` with `sel`≠11, or with `ret`=0, is a plain push.

## Timing
- Reset takes effect on a sampled `clk` edge with `reset`=1 and overrides all other inputs. Values after reset:
  - `pc_out` = RESET_VEC;
  - `ras_count` = 0, and all RAS entries = 0;
  - `ras_overflow`, `ras_underflow` and `misalign` = 0.
- A reset mid-operation discards any pending update in the same cycle.
- Sticky flags clear only on reset.
- Latency:
  - `pc_out` and the RAS reflect an update one cycle after the edge at which `upd` was sampled.
  - `pc_plus4` and `ras_top` follow combinationally, in the same cycle.
- `misalign` is registered: high exactly one cycle after the rejecting edge, then returns low unless rejected again.
- Inputs are sampled only at the update edge. There is no handshake; the controller holds `UPDATE_STATE` for exactly one cycle per instruction.

## Test plan
- Reset, then `upd` with `sel`=00 for 3 cycles → `pc_out` = 0, 4, 8, 12. Assert `reset` with `upd` active → next cycle `pc_out` = RESET_VEC, `ras_count` = 0, all flags 0.
- Gating: with `pc_out`=0x100, `sel`=00, try each of `state`≠UPDATE_STATE, `pc_en`=0 and `stall`=1 → `pc_out` stays 0x100.
- Branch and jump:
  - `pc_out`=0x40, `sel`=01, `br_taken`=1, `br_offset`=-3 → 0x38.
  - Same with `br_taken`=0 → 0x44.
  - `pc_out`=0xF000_0010, `sel`=10, `jtarget`=0x0000_100 → 0xF000_0400.
  - `pc_out`=0xFFFF_FFFC, `sel`=00 → wraps to 0.
- RAS call/return: `jal` at 0x100 (`link`=1, `sel`=10) → `ras_top`=0x104, `ras_count`=1. Then `sel`=11, `ret`=1, `jr_target`=0x999 → `pc_out`=0x104, `ras_count`=0.
- RAS boundaries:
  - 5 pushes with RAS_DEPTH=4 → `ras_count`=4, `ras_overflow`=1, and the first pushed value is lost on 4 pops.
  - A pop when empty with `jr_target`=0x200 → `pc_out`=0x200, `ras_underflow`=1.
  - Simultaneous push and pop → count unchanged, target = old top.
- Misalign: `sel`=11, `ret`=0, `jr_target`=0x202 → `pc_out` holds, `misalign`=1 for one cycle, RAS unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for the multicycle MIPS core.
// Holds the architectural PC and selects the next PC (sequential, branch,
// absolute jump, register jump). A small return-address stack (RAS) serves
// jal / jr $ra pairs. The PC changes only when the controller is in
// UPDATE_STATE with pc_en set and no stall.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   state             controller state code
//   pc_en, stall      PC write enable; stall overrides pc_en
//   sel               next-PC source: 00 seq, 01 branch, 10 jump, 11 reg jump
//   br_taken          branch condition (sel=01)
//   br_offset         sign-extended word offset
//   jtarget           J-format 26-bit target field
//   jr_target         register operand (sel=11)
//   link, ret         push pc_plus4 onto RAS / take sel=11 target from RAS top
//   pc_out, pc_plus4  registered PC and PC+4
//   ras_top,ras_count RAS top entry (0 when empty) and entry count
//   ras_overflow      sticky: push while full
//   ras_underflow     sticky: pop while empty
//   misalign          one-cycle pulse: an update was rejected
module pc_sequencer #(
   parameter int                   XLEN         = 32,
   parameter logic [XLEN-1:0]      RESET_VEC    = 32'h0000_0000,
   parameter int                   RAS_DEPTH    = 4,
   parameter int                   STATE_W      = 6,
   parameter logic [STATE_W-1:0]   UPDATE_STATE = 6'b000001
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [STATE_W-1:0]                 state,
   input  logic                               pc_en,
   input  logic                               stall,
   input  logic [1:0]                         sel,
   input  logic                               br_taken,
   input  logic [XLEN-1:0]                    br_offset,
   input  logic [25:0]                        jtarget,
   input  logic [XLEN-1:0]                    jr_target,
   input  logic                               link,
   input  logic                               ret,
   output logic [XLEN-1:0]                    pc_out,
   output logic [XLEN-1:0]                    pc_plus4,
   output logic [XLEN-1:0]                    ras_top,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
   output logic                               ras_overflow,
   output logic                               ras_underflow,
   output logic                               misalign
);

   localparam int CW = $clog2(RAS_DEPTH+1);

   // Entry 0 is always the top; deeper entries are older. A push onto a
   // full stack shifts the oldest entry out of the bottom.
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];

   logic [XLEN-1:0] jmp_tgt;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] target;
   logic            upd;
   logic            bad;
   logic            has_entry;
   logic            full;
   logic            pop_req;
   logic            pop_ok;
   logic            push;

   assign pc_plus4  = pc_out + XLEN'(4);
   assign has_entry = (ras_count != '0);
   assign full      = (ras_count == CW'(RAS_DEPTH));
   assign ras_top   = has_entry ? ras_mem[0] : '0;
   assign br_tgt    = pc_plus4 + (br_offset << 2);

   generate
      if (XLEN > 28) begin : g_jmp_hi
         assign jmp_tgt = {pc_plus4[XLEN-1:28], jtarget, 2'b00};
      end else begin : g_jmp_lo
         assign jmp_tgt = {jtarget, 2'b00};
      end
   endgenerate

   assign upd = (state == UPDATE_STATE) & pc_en & ~stall & ~reset;

   always_comb begin
      target = pc_plus4;
      case (sel)
         2'b00: target = pc_plus4;
         2'b01: target = br_taken ? br_tgt : pc_plus4;
         2'b10: target = jmp_tgt;
         2'b11: target = (ret & has_entry) ? ras_mem[0] : jr_target;
         default: target = pc_plus4;
      endcase
   end

   // A misaligned target cancels the whole update, RAS activity included.
   assign bad     = (target[1:0] != 2'b00);
   assign pop_req = upd & ~bad & (sel == 2'b11) & ret;
   assign pop_ok  = pop_req & has_entry;
   assign push    = upd & ~bad & link;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out        <= RESET_VEC;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
         misalign      <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      end else begin
         misalign <= upd & bad;
         if (upd & ~bad) pc_out <= target;
         if (pop_req & ~has_entry) ras_underflow <= 1'b1;

         if (push & pop_ok) begin
            // pop then push: the new return address replaces the old top
            ras_mem[0] <= pc_plus4;
         end else if (push) begin
            for (int i = RAS_DEPTH-1; i > 0; i--) ras_mem[i] <= ras_mem[i-1];
            ras_mem[0] <= pc_plus4;
            if (full) ras_overflow <= 1'b1;
            else      ras_count    <= ras_count + CW'(1);
         end else if (pop_ok) begin
            for (int i = 0; i < RAS_DEPTH-1; i++) ras_mem[i] <= ras_mem[i+1];
            ras_mem[RAS_DEPTH-1] <= '0;
            ras_count <= ras_count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan sequences followed by random
// traffic. Each driven cycle runs a queue-based reference model and pushes
// the expected post-edge state into a scoreboard; a monitor compares it.
module tb_pc_sequencer;

   localparam int          XLEN  = 32;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam int          DEPTH = 4;
   localparam logic [5:0]  UPD   = 6'b000001;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  state;
   logic        pc_en, stall, br_taken, link, ret;
   logic [1:0]  sel;
   logic [31:0] br_offset, jr_target;
   logic [25:0] jtarget;
   logic [31:0] pc_out, pc_plus4, ras_top;
   logic [2:0]  ras_count;
   logic        ras_overflow, ras_underflow, misalign;

   always #5 clk = ~clk;

   pc_sequencer #(.XLEN(XLEN), .RESET_VEC(RV), .RAS_DEPTH(DEPTH),
                  .STATE_W(6), .UPDATE_STATE(UPD)) dut (
      .clk(clk), .reset(reset), .state(state), .pc_en(pc_en), .stall(stall),
      .sel(sel), .br_taken(br_taken), .br_offset(br_offset),
      .jtarget(jtarget), .jr_target(jr_target), .link(link), .ret(ret),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .ras_top(ras_top),
      .ras_count(ras_count), .ras_overflow(ras_overflow),
      .ras_underflow(ras_underflow), .misalign(misalign));

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic [31:0] top;
      logic        ovf, unf, mis;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_ras[$];   // front = top of stack
   logic [31:0] m_pc;
   logic        m_ovf, m_unf, m_mis;
   int          n_total = 0;
   int          n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
   endtask

   // Reference model: one call per clock, inputs already applied.
   task automatic cyc();
      exp_t        e;
      logic [31:0] p4, tgt;
      logic        u;
      u  = (state == UPD) && pc_en && !stall && !reset;
      p4 = m_pc + 32'd4;
      if (reset) begin
         m_pc = RV; m_ras.delete(); m_ovf = 0; m_unf = 0; m_mis = 0;
      end else if (!u) begin
         m_mis = 0;
      end else begin
         case (sel)
            2'b00: tgt = p4;
            2'b01: tgt = br_taken ? p4 + br_offset * 4 : p4;
            2'b10: tgt = {p4[31:28], jtarget, 2'b00};
            default: tgt = (ret && m_ras.size() > 0) ? m_ras[0] : jr_target;
         endcase
         if (tgt[1:0] != 2'b00) m_mis = 1;
         else begin
            m_mis = 0;
            if (sel == 2'b11 && ret) begin
               if (m_ras.size() > 0) void'(m_ras.pop_front());
               else m_unf = 1;
            end
            if (link) begin
               m_ras.push_front(p4);
               if (m_ras.size() > DEPTH) begin
                  void'(m_ras.pop_back());
                  m_ovf = 1;
               end
            end
            m_pc = tgt;
         end
      end
      e.pc  = m_pc;
      e.cnt = 3'(m_ras.size());
      e.top = (m_ras.size() > 0) ? m_ras[0] : 32'd0;
      e.ovf = m_ovf; e.unf = m_unf; e.mis = m_mis;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 0; state = 6'd0; pc_en = 0; stall = 0; sel = 0;
      link = 0; ret = 0;
   endtask

   task automatic go(input logic [1:0] s, input logic lk, input logic rt, input logic [31:0] jr);
      reset = 0; state = UPD; pc_en = 1; stall = 0;
      sel = s; link = lk; ret = rt; jr_target = jr;
      cyc();
   endtask

   task automatic do_reset();
      reset = 1; cyc(); reset = 0;
   endtask

   // Monitor: every cycle with a pending expectation is compared.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_out",        pc_out,               e.pc);
            chk("pc_plus4",      pc_plus4,             e.pc + 32'd4);
            chk("ras_count",     {29'd0, ras_count},   {29'd0, e.cnt});
            chk("ras_top",       ras_top,              e.top);
            chk("ras_overflow",  {31'd0, ras_overflow},  {31'd0, e.ovf});
            chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, e.unf});
            chk("misalign",      {31'd0, misalign},    {31'd0, e.mis});
         end
      end
   end

   initial begin
      idle();
      reset = 1; br_taken = 0; br_offset = 0; jtarget = 0; jr_target = 0;
      m_pc = 32'hx; m_ovf = 0; m_unf = 0; m_mis = 0;
      @(negedge clk);
      do_reset(); do_reset();

      // sequential, then reset with an active update
      go(2'b00, 0, 0, 0); go(2'b00, 0, 0, 0); go(2'b00, 0, 0, 0);
      state = UPD; pc_en = 1; reset = 1; cyc(); reset = 0;

      // gating
      go(2'b11, 0, 0, 32'h100);
      go(2'b00, 0, 0, 0); state = 6'd2; cyc();
      go(2'b11, 0, 0, 32'h100);
      go(2'b00, 0, 0, 0); pc_en = 0; cyc();
      go(2'b00, 0, 0, 0); stall = 1; cyc();

      // branch taken / not taken
      go(2'b11, 0, 0, 32'h40);
      br_taken = 1; br_offset = -32'sd3; go(2'b01, 0, 0, 0);
      go(2'b11, 0, 0, 32'h40);
      br_taken = 0; go(2'b01, 0, 0, 0);

      // jump keeps upper nibble; sequential wrap
      go(2'b11, 0, 0, 32'hF000_0010);
      jtarget = 26'h0000_100; go(2'b10, 0, 0, 0);
      go(2'b11, 0, 0, 32'hFFFF_FFFC);
      go(2'b00, 0, 0, 0);

      // call / return
      do_reset();
      go(2'b11, 0, 0, 32'h100);
      jtarget = 26'h40; go(2'b10, 1, 0, 0);
      go(2'b11, 0, 1, 32'h999);

      // overflow: 5 pushes, then drain with 4 pops, then underflow
      for (int i = 0; i < 5; i++) go(2'b00, 1, 0, 0);
      for (int i = 0; i < 4; i++) go(2'b11, 0, 1, 32'h500);
      go(2'b11, 0, 1, 32'h200);

      // simultaneous push and pop, non-empty then empty
      do_reset();
      go(2'b00, 1, 0, 0); go(2'b00, 1, 0, 0);
      go(2'b11, 1, 1, 32'h700);
      go(2'b11, 0, 1, 32'h300); go(2'b11, 0, 1, 32'h300);
      go(2'b11, 1, 1, 32'h600);

      // misalign rejects update and leaves RAS alone
      go(2'b00, 1, 0, 0);
      go(2'b11, 1, 0, 32'h202);
      idle(); cyc(); cyc();

      // randomized traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         reset     = ($urandom_range(0, 63) == 0);
         state     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : UPD;
         pc_en     = ($urandom_range(0, 9) != 0);
         stall     = ($urandom_range(0, 9) == 0);
         sel       = 2'($urandom);
         br_taken  = 1'($urandom);
         br_offset = 32'($signed($urandom_range(0, 255)) - 128);
         jtarget   = 26'($urandom);
         jr_target = {$urandom} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) jr_target[1:0] = 2'($urandom);
         link      = ($urandom_range(0, 9) < 3);
         ret       = 1'($urandom);
         cyc();
      end
      idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
